// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder. The master drives the decode controls and the
// slave returns the registered decode results.
interface scan_decoder_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned W = 1 << N;

    logic         en;
    logic         mode;
    logic [N-1:0] sel;
    logic         load;
    logic         step;
    logic [N-1:0] last;
    logic [W-1:0] out;
    logic [N-1:0] idx;
    logic         valid;
    logic         wrap;

    modport master (
        output en, mode, sel, load, step, last,
        input  out, idx, valid, wrap
    );

    modport slave (
        input  en, mode, sel, load, step, last,
        output out, idx, valid, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// One-hot decoder with a direct mode (decode sel) and a scan mode that walks a
// counter from a loaded start index up to a terminal index, then wraps to 0.
module scan_decoder #(
    parameter int unsigned N = 3
) (
    input  logic          clk,
    input  logic          rst,
    scan_decoder_if.slave bus
);
    localparam int unsigned W = 1 << N;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q,   cnt_d;
    logic [N-1:0] idx_q,   idx_d;
    logic [W-1:0] out_q,   out_d;
    logic         valid_q, valid_d;
    logic         wrap_q,  wrap_d;

    // Outputs are computed from the post-edge state, so every decode is visible
    // one clock after the inputs that caused it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (bus.en) begin
            if (!bus.mode) begin
                state_d = IDLE;
                idx_d   = bus.sel;
                out_d   = W'(1) << bus.sel;
                valid_d = 1'b1;
            end else begin
                if (bus.load) begin
                    state_d = RUN;
                    cnt_d   = bus.sel;
                end else if (state_q == RUN && bus.step) begin
                    if (cnt_q < bus.last) begin
                        cnt_d = cnt_q + N'(1);
                    end else begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end

                if (state_d == RUN) begin
                    idx_d   = cnt_d;
                    out_d   = W'(1) << cnt_d;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder (N=3): an integer-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_scan_decoder;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    scan_decoder_if #(.N(N)) bus();

    scan_decoder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: whether a scan is running, its position, and the
    // index last presented on the outputs.
    bit         m_run  = 1'b0;
    int         m_cnt  = 0;
    int         m_idx  = 0;
    logic [7:0] e_out  = '0;
    bit         e_valid = 1'b0;
    bit         e_wrap  = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model on each edge, then compare all outputs shortly after.
    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_idx = 0;
            e_out = '0; e_valid = 1'b0; e_wrap = 1'b0;
        end else if (!bus.en) begin
            e_out = '0; e_valid = 1'b0; e_wrap = 1'b0;
        end else if (!bus.mode) begin
            m_run = 1'b0;
            m_idx = int'(bus.sel);
            e_out = 8'(1) << m_idx;
            e_valid = 1'b1; e_wrap = 1'b0;
        end else begin
            e_wrap = 1'b0;
            if (bus.load) begin
                m_run = 1'b1;
                m_cnt = int'(bus.sel);
            end else if (m_run && bus.step) begin
                if (m_cnt < int'(bus.last)) m_cnt = (m_cnt + 1) % 8;
                else begin m_cnt = 0; e_wrap = 1'b1; end
            end
            if (m_run) begin
                m_idx = m_cnt;
                e_out = 8'(1) << m_cnt;
                e_valid = 1'b1;
            end else begin
                e_out = '0; e_valid = 1'b0;
            end
        end
        #1;
        checks++;
        if (bus.out !== e_out || bus.idx !== 3'(m_idx) || bus.valid !== e_valid ||
            bus.wrap !== e_wrap || (bus.valid ? $countones(bus.out) != 1 : bus.out != 0)) begin
            errors++;
            $display("FAIL model: got out=%b idx=%0d valid=%b wrap=%b expected out=%b idx=%0d valid=%b wrap=%b at %0t",
                     bus.out, bus.idx, bus.valid, bus.wrap, e_out, m_idx, e_valid, e_wrap, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit en, input bit mode, input int sel, input bit load,
                         input bit step, input int last);
        bus.en = en; bus.mode = mode; bus.sel = 3'(sel);
        bus.load = load; bus.step = step; bus.last = 3'(last);
    endtask

    int exp_a[];
    int wrp_a[];

    initial begin
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        tick(); tick();
        chk("reset_out", int'(bus.out), 0);
        chk("reset_idx", int'(bus.idx), 0);
        chk("reset_valid", int'(bus.valid), 0);
        rst = 1'b0;

        // Direct sweep
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, i, 1'b0, 1'b0, 0);
            tick();
            chk("direct_idx", int'(bus.idx), i);
            chk("direct_valid", int'(bus.valid), 1);
        end
        drive(1'b1, 1'b0, 5, 1'b1, 1'b1, 0);
        tick();
        chk("direct_out5", int'(bus.out), 32);
        chk("direct_wrap", int'(bus.wrap), 0);

        // Full scan 0..7 then wrap
        drive(1'b1, 1'b1, 0, 1'b1, 1'b0, 7);
        tick();
        chk("full_start", int'(bus.idx), 0);
        bus.load = 1'b0; bus.step = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("full_idx", int'(bus.idx), i % 8);
            chk("full_wrap", int'(bus.wrap), (i == 8) ? 1 : 0);
        end
        chk("full_out0", int'(bus.out), 1);

        // Out-of-range start
        exp_a = '{6, 0, 1, 2, 3, 0};
        wrp_a = '{0, 1, 0, 0, 0, 1};
        drive(1'b1, 1'b1, 6, 1'b1, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("part_idx", int'(bus.idx), exp_a[i]);
            chk("part_wrap", int'(bus.wrap), wrp_a[i]);
            bus.load = 1'b0; bus.step = 1'b1;
        end

        // Load beats step
        drive(1'b1, 1'b1, 2, 1'b1, 1'b0, 7);
        tick();
        chk("ls_pre", int'(bus.idx), 2);
        drive(1'b1, 1'b1, 5, 1'b1, 1'b1, 7);
        tick();
        chk("ls_idx", int'(bus.idx), 5);
        chk("ls_wrap", int'(bus.wrap), 0);

        // Enable gating
        drive(1'b1, 1'b1, 4, 1'b1, 1'b0, 7);
        tick();
        drive(1'b0, 1'b1, 0, 1'b0, 1'b1, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_out", int'(bus.out), 0);
            chk("gap_valid", int'(bus.valid), 0);
        end
        drive(1'b1, 1'b1, 0, 1'b0, 1'b0, 7);
        tick();
        chk("resume_idx", int'(bus.idx), 4);
        bus.step = 1'b1;
        tick();
        chk("resume_step", int'(bus.idx), 5);

        // Reset mid-scan
        drive(1'b1, 1'b1, 3, 1'b1, 1'b0, 7);
        tick();
        chk("rst_pre", int'(bus.idx), 3);
        rst = 1'b1;
        tick();
        chk("rst_out", int'(bus.out), 0);
        chk("rst_idx", int'(bus.idx), 0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 6, 1'b0, 1'b1, 7);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_out", int'(bus.out), 0);
        end

        // Mode 0 -> 1 needs a load
        drive(1'b1, 1'b0, 2, 1'b0, 1'b0, 7);
        tick();
        drive(1'b1, 1'b1, 2, 1'b0, 1'b1, 7);
        tick();
        chk("mode_sw_valid", int'(bus.valid), 0);

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            bus.en   = ($urandom_range(0, 9) != 0);
            bus.mode = ($urandom_range(0, 4) != 0);
            bus.sel  = 3'($urandom_range(0, 7));
            bus.load = ($urandom_range(0, 7) == 0);
            bus.step = ($urandom_range(0, 1) == 1);
            bus.last = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
